// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel/line position from HS/VS, locks to the
// expected frame timing and counts timing errors. Optional macro: VGA_SYNC_MONITOR_SYNC2FF_EN.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       PIX_EN,
    input  logic       HS,
    input  logic       VS,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       ACTIVE,
    output logic       LOCKED,
    output logic       FRAME_START,
    output logic [7:0] ERR_CNT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_CHECK = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    localparam logic [9:0] L_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] L_H_END   = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] L_V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] L_V_END   = 10'(V_SYNC + V_BP + V_ACT);
    localparam logic [2:0] L_LOCK    = 3'(LOCK_FRAMES);

    logic       w_hs;
    logic       w_vs;

`ifdef VGA_SYNC_MONITOR_SYNC2FF_EN
    logic [1:0] r_hs_sync;
    logic [1:0] r_vs_sync;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_hs_sync <= '1;
            r_vs_sync <= '1;
        end else begin
            r_hs_sync <= {r_hs_sync[0], HS};
            r_vs_sync <= {r_vs_sync[0], VS};
        end
    end

    assign w_hs = r_hs_sync[1];
    assign w_vs = r_vs_sync[1];
`else
    assign w_hs = HS;
    assign w_vs = VS;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_hs_prev;
    logic       r_vs_prev;
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic [2:0] r_good;
    logic       r_frame_err;
    logic [7:0] r_err;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_active;
    logic       r_locked;
    logic       r_fs;

    logic       w_hs_fall;
    logic       w_vs_fall;
    logic [9:0] w_hcnt_nxt;
    logic [9:0] w_vcnt_nxt;
    logic       w_h_sat;
    logic       w_v_sat;
    logic       w_h_err;
    logic       w_v_err;
    logic       w_any_err;
    logic [2:0] w_good_nxt;
    logic [2:0] w_good_inc;
    logic [1:0] w_err_inc;
    logic [8:0] w_err_sum;
    logic       w_act_nxt;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;

    assign w_hs_fall = PIX_EN & r_hs_prev & ~w_hs;
    assign w_vs_fall = PIX_EN & r_vs_prev & ~w_vs;
    assign w_h_err   = w_hs_fall && (r_hcnt != L_H_LAST) && (r_state != S_HUNT);
    assign w_v_err   = w_vs_fall && (r_vcnt != L_V_LAST) && (r_state != S_HUNT);
    assign w_any_err = w_h_err | w_v_err;
    assign w_good_inc = r_good + 3'd1;

    // Saturation is flagged only on the step into 1023 so a stuck counter counts once.
    always_comb begin
        w_hcnt_nxt = r_hcnt;
        w_vcnt_nxt = r_vcnt;
        w_h_sat    = 1'b0;
        w_v_sat    = 1'b0;
        if (PIX_EN) begin
            if (w_hs_fall) begin
                w_hcnt_nxt = '0;
            end else if (r_hcnt != '1) begin
                w_hcnt_nxt = r_hcnt + 10'd1;
                w_h_sat    = (r_hcnt == 10'd1022);
            end
            if (w_vs_fall) begin
                w_vcnt_nxt = '0;
            end else if (w_hs_fall && (r_vcnt != '1)) begin
                w_vcnt_nxt = r_vcnt + 10'd1;
                w_v_sat    = (r_vcnt == 10'd1022);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (PIX_EN) begin
            if (w_h_sat || w_v_sat) begin
                w_state_nxt = S_HUNT;
                w_good_nxt  = '0;
            end else begin
                case (r_state)
                    S_HUNT: begin
                        if (w_vs_fall) begin
                            w_state_nxt = S_CHECK;
                            w_good_nxt  = '0;
                        end
                    end
                    S_CHECK: begin
                        if (w_vs_fall) begin
                            if (!r_frame_err && !w_any_err) begin
                                w_good_nxt = w_good_inc;
                                if (w_good_inc == L_LOCK) begin
                                    w_state_nxt = S_LOCK;
                                end
                            end else begin
                                w_good_nxt = '0;
                            end
                        end
                    end
                    S_LOCK: begin
                        if (w_any_err) begin
                            w_state_nxt = S_CHECK;
                            w_good_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = S_HUNT;
                        w_good_nxt  = '0;
                    end
                endcase
            end
        end
    end

    assign w_err_inc = 2'(w_any_err) + 2'(w_h_sat) + 2'(w_v_sat);
    assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};

    // Outputs are derived from the post-update counters so they align with the sampled tick.
    assign w_act_nxt = (w_hcnt_nxt >= L_H_START) && (w_hcnt_nxt < L_H_END) &&
                       (w_vcnt_nxt >= L_V_START) && (w_vcnt_nxt < L_V_END) &&
                       (w_state_nxt == S_LOCK);
    assign w_x_nxt   = w_act_nxt ? (w_hcnt_nxt - L_H_START) : '0;
    assign w_y_nxt   = w_act_nxt ? (w_vcnt_nxt - L_V_START) : '0;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= S_HUNT;
            r_hs_prev   <= 1'b1;
            r_vs_prev   <= 1'b1;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_good      <= '0;
            r_frame_err <= 1'b0;
            r_err       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_active    <= 1'b0;
            r_locked    <= 1'b0;
            r_fs        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_vcnt   <= w_vcnt_nxt;
            r_locked <= (w_state_nxt == S_LOCK);
            r_fs     <= PIX_EN && w_act_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
            r_err    <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            if (PIX_EN) begin
                r_hs_prev <= w_hs;
                r_vs_prev <= w_vs;
                r_active  <= w_act_nxt;
                r_x       <= w_x_nxt;
                r_y       <= w_y_nxt;
                if (w_vs_fall) begin
                    r_frame_err <= 1'b0;
                end else if (w_h_err) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign X           = r_x;
    assign Y           = r_y;
    assign ACTIVE      = r_active;
    assign LOCKED      = r_locked;
    assign FRAME_START = r_fs;
    assign ERR_CNT     = r_err;
    assign STATE       = r_state;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a scaled-down 40x20 timing so many frames fit.
module tb_vga_sync_monitor;

    localparam int HT  = 40;
    localparam int HSY = 4;
    localparam int HBP = 4;
    localparam int HA  = 24;
    localparam int VT  = 20;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int VA  = 12;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       PIX_EN = 1'b0;
    logic       HS = 1'b1;
    logic       VS = 1'b1;
    logic [9:0] X;
    logic [9:0] Y;
    logic       ACTIVE;
    logic       LOCKED;
    logic       FRAME_START;
    logic [7:0] ERR_CNT;
    logic [1:0] STATE;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HSY), .H_BP(HBP), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VSY), .V_BP(VBP), .V_ACT(VA),
        .LOCK_FRAMES(2)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .PIX_EN(PIX_EN), .HS(HS), .VS(VS),
        .X(X), .Y(Y), .ACTIVE(ACTIVE), .LOCKED(LOCKED), .FRAME_START(FRAME_START),
        .ERR_CNT(ERR_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned tick;
        string       name;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic        lck;
        logic        fs;
        logic [7:0]  err;
        logic [1:0]  st;
    } exp_t;

    exp_t        q[$];
    int unsigned g_tick  = 0;
    int unsigned m_tick  = 0;
    int unsigned fs_seen = 0;
    int          tests   = 0;
    int          fails   = 0;

    task automatic check_vec(input exp_t e);
        tests++;
        if ({X, Y, ACTIVE, LOCKED, FRAME_START, ERR_CNT, STATE} !==
            {e.x, e.y, e.act, e.lck, e.fs, e.err, e.st}) begin
            fails++;
            $display("FAIL %s (tick %0d): got X=%0d Y=%0d ACT=%0b LCK=%0b FS=%0b ERR=%0d ST=%0d, want X=%0d Y=%0d ACT=%0b LCK=%0b FS=%0b ERR=%0d ST=%0d",
                     e.name, e.tick, X, Y, ACTIVE, LOCKED, FRAME_START, ERR_CNT, STATE,
                     e.x, e.y, e.act, e.lck, e.fs, e.err, e.st);
        end
    endtask

    function automatic exp_t mk(input string n, input int st, input int err, input bit act,
                                input int x, input int y, input bit fs);
        exp_t e;
        e.tick = g_tick;
        e.name = n;
        e.st   = 2'(st);
        e.lck  = (st == 2);
        e.err  = 8'(err);
        e.act  = act;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.fs   = fs;
        return e;
    endfunction

    task automatic do_tick(input bit hs, input bit vs);
        @(negedge CLK);
        HS     = hs;
        VS     = vs;
        PIX_EN = 1'b1;
        @(negedge CLK);
        PIX_EN = 1'b0;
        g_tick++;
    endtask

    // Ideal frame (optionally short or with one long line); expectations pushed at checkpoints.
    task automatic send_frame(input int lines, input int bad_line, input int bad_len,
                              input int st0, input int err0, input int stb, input int errb);
        bit lk;
        int len;
        lk = (stb == 2);
        for (int v = 0; v < lines; v++) begin
            len = (v == bad_line) ? bad_len : HT;
            for (int h = 0; h < len; h++) begin
                if (v == 0 && h == 0)
                    q.push_back(mk("frame_edge", st0, err0, 1'b0, 0, 0, 1'b0));
                if (bad_line >= 0 && v == bad_line + 1 && h == 0)
                    q.push_back(mk("long_line_err", stb, errb, 1'b0, 0, 0, 1'b0));
                if (v == VSY + VBP && h == HSY + HBP)
                    q.push_back(mk("first_pixel", stb, errb, lk, 0, 0, lk));
                if (v == VSY + VBP + VA - 1 && h == HSY + HBP + HA - 1)
                    q.push_back(mk("last_pixel", stb, errb, lk, lk ? HA - 1 : 0, lk ? VA - 1 : 0, 1'b0));
                if (v == VSY + VBP + VA - 1 && h == HSY + HBP + HA)
                    q.push_back(mk("after_last", stb, errb, 1'b0, 0, 0, 1'b0));
                do_tick(h >= HSY, v >= VSY);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            if (PIX_EN && RESETN) begin
                #1;
                if (q.size() > 0 && q[0].tick == m_tick) begin
                    e = q.pop_front();
                    check_vec(e);
                end
                m_tick++;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (FRAME_START === 1'b1) fs_seen++;
    end

    initial begin : stimulus
        int waited;
        RESETN = 1'b0;
        repeat (3) @(negedge CLK);
        check_vec(mk("reset_state", 0, 0, 1'b0, 0, 0, 1'b0));
        RESETN = 1'b1;
        @(negedge CLK);

        send_frame(VT, -1, 0, 1, 0, 1, 0);
        send_frame(VT, -1, 0, 1, 0, 1, 0);
        send_frame(VT, -1, 0, 2, 0, 2, 0);
        send_frame(VT, 3, HT + 1, 2, 0, 1, 1);
        send_frame(VT, -1, 0, 1, 1, 1, 1);
        send_frame(VT, -1, 0, 1, 1, 1, 1);
        send_frame(VT, -1, 0, 2, 1, 2, 1);
        send_frame(VT - 1, -1, 0, 2, 1, 2, 1);
        send_frame(VT, -1, 0, 1, 2, 1, 2);
        send_frame(VT, -1, 0, 1, 2, 1, 2);
        send_frame(VT, -1, 0, 2, 2, 2, 2);

        // HS stuck high: hcnt reaches 1023 after 984 ticks of this stretch.
        for (int i = 0; i < 1100; i++) begin
            if (i == 900)  q.push_back(mk("pre_saturation", 2, 2, 1'b0, 0, 0, 1'b0));
            if (i == 1099) q.push_back(mk("hs_stuck_hunt", 0, 3, 1'b0, 0, 0, 1'b0));
            do_tick(1'b1, 1'b1);
        end

        // First tick has HS and VS falling together; Y and V checks reveal any vcnt offset.
        send_frame(VT, -1, 0, 1, 3, 1, 3);
        send_frame(VT, -1, 0, 1, 3, 1, 3);
        send_frame(VT, -1, 0, 2, 3, 2, 3);

        for (int v = 0; v < 6; v++)
            for (int h = 0; h < HT; h++)
                do_tick(h >= HSY, v >= VSY);
        for (int h = 0; h <= 10; h++) begin
            if (h == 10) q.push_back(mk("pre_reset_active", 2, 3, 1'b1, 2, 1, 1'b0));
            do_tick(h >= HSY, 1'b1);
        end

        @(posedge CLK);
        #3;
        RESETN = 1'b0;
        #1;
        check_vec(mk("async_reset", 0, 0, 1'b0, 0, 0, 1'b0));
        @(negedge CLK);
        RESETN = 1'b1;

        for (int i = 0; i < 50; i++) begin
            if (i == 49) q.push_back(mk("post_reset_idle", 0, 0, 1'b0, 0, 0, 1'b0));
            do_tick(1'b1, 1'b1);
        end
        q.push_back(mk("post_reset_vs_fall", 1, 0, 1'b0, 0, 0, 1'b0));
        do_tick(1'b0, 1'b0);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", q.size());
        end

        tests++;
        if (fs_seen != 6) begin
            fails++;
            $display("FAIL frame_start_pulses: got %0d CLK-high cycles, want 6", fs_seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
